// File: rtl/load_store_unit.sv
// RV32I load/store unit: one req/ack data-bus transaction per instruction,
// lane-aligned store data with byte enables, sign/zero-extended load results.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      funct3,
    input  logic            is_store,
    output logic            ready,
    output logic            done,
    output logic            fault,
    output logic [XLEN-1:0] rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, FIN} state_t;

    state_t          state, state_nxt;
    logic            accept, legal, aligned;
    logic [3:0]      be_nxt;
    logic [XLEN-1:0] wdata_nxt;

    logic            fault_q;
    logic [XLEN-1:0] rdata_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [3:0]      be_q;
    logic [2:0]      f3_q;
    logic [1:0]      k_q;

    function automatic logic [XLEN-1:0] extend_load(
        input logic [2:0]      f3,
        input logic [1:0]      k,
        input logic [XLEN-1:0] word
    );
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [XLEN-1:0] ext;
        b = word[{k, 3'b000} +: 8];
        h = word[{k[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  ext = b;
            3'b001:  ext = h;
            3'b100:  ext = {{(XLEN-8){1'b0}}, b};
            3'b101:  ext = {{(XLEN-16){1'b0}}, h};
            default: ext = word;
        endcase
        return ext;
    endfunction

    // Decode of the incoming request: legality, alignment, lanes
    always_comb begin
        if (is_store) begin
            legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        end else begin
            legal = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
        end
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00:   be_nxt = 4'b0001 << addr[1:0];
            2'b01:   be_nxt = addr[1] ? 4'b1100 : 4'b0011;
            default: be_nxt = 4'b1111;
        endcase
        if (!is_store) begin
            wdata_nxt = '0;
        end else begin
            case (funct3[1:0])
                2'b00:   wdata_nxt = {4{wdata[7:0]}};
                2'b01:   wdata_nxt = {2{wdata[15:0]}};
                default: wdata_nxt = wdata;
            endcase
        end
    end

    assign accept = start && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE, FIN: begin
                ready     = 1'b1;
                done      = (state == FIN);
                state_nxt = IDLE;
                if (start) begin
                    state_nxt = (legal && aligned) ? BUS : FIN;
                end
            end
            BUS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status: fault flag for the pending completion and the held load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                fault_q <= !(legal && aligned);
            end
            if (state == BUS && mem_ack && !we_q) begin
                rdata_q <= extend_load(f3_q, k_q, mem_rdata);
            end
        end
    end

    // Operand latch; only observed while in BUS, so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= is_store;
            addr_q  <= {addr[XLEN-1:2], 2'b00};
            be_q    <= be_nxt;
            wdata_q <= wdata_nxt;
            f3_q    <= funct3;
            k_q     <= addr[1:0];
        end
    end

    assign fault     = (state == FIN) && fault_q;
    assign rdata     = rdata_q;
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_be    = mem_req ? be_q    : 4'b0000;
    assign mem_wdata = mem_req ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed scenarios plus randomized
// traffic checked against an arithmetic reference model and a bus responder.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic        is_store = 1'b0;
    logic        ready, done, fault, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata = '0;

    logic        manual = 1'b0;
    logic        man_ack = 1'b0;
    logic        resp_ack = 1'b0;
    assign mem_ack = manual ? man_ack : resp_ack;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
        .funct3(funct3), .is_store(is_store), .ready(ready), .done(done),
        .fault(fault), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wt;
        int          icyc;
    } bus_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          icyc;
    } res_t;

    bus_t bq[$];
    res_t rq[$];

    int n_checks = 0;
    int n_fail = 0;
    int issued = 0;
    int completed = 0;
    logic [31:0] last_load = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, phrased in terms of access size in bytes
    function automatic bit m_legal(input bit st, input logic [2:0] f3);
        if (st) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
        int nbytes = 1 << f3[1:0];
        return (a % nbytes) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int nbytes = 1 << f3[1:0];
        int mask = ((1 << nbytes) - 1) << a[1:0];
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = '0;
        int nbytes = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int bits = 8 << f3[1:0];
        longint v = longint'((rd >> (8 * a[1:0]))) & ((longint'(1) << bits) - 1);
        if (!f3[2] && bits < 32 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int wt,
                         input logic efault, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] erd, output int icyc);
        int guard = 0;
        icyc = -1;
        while (!ready && guard < 100) begin
            start    = ($urandom_range(0, 3) == 0);
            is_store = 1'($urandom);
            funct3   = 3'($urandom);
            addr     = $urandom;
            wdata    = $urandom;
            step();
            guard++;
        end
        if (!ready) begin
            check("ready_timeout", ready, 1);
            start = 1'b0;
            return;
        end
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        icyc = cyc;
        if (!efault) bq.push_back('{st, {a[31:2], 2'b00}, ebe, ewd, rd, wt, cyc});
        rq.push_back('{efault, erd, cyc});
        issued++;
        step();
        start = 1'b0;
    endtask

    task automatic issue_rand();
        logic st, ok;
        logic [2:0] f3;
        logic [31:0] a, wd, rd, erd;
        int ic;
        st = 1'($urandom);
        f3 = 3'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
        end
        a = $urandom;
        if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
        wd = $urandom;
        rd = $urandom;
        ok = m_legal(st, f3) && m_aligned(f3, a);
        if (ok && !st) last_load = m_load(f3, a, rd);
        erd = last_load;
        issue(st, f3, a, wd, rd, $urandom_range(0, 3), !ok, m_be(f3, a),
              st ? m_wdata(f3, wd) : 32'h0, erd, ic);
    endtask

    task automatic check_reset_values();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
    endtask

    // Bus responder: pops expected bus transfers, checks them, acks after wt cycles
    initial begin
        bus_t cur;
        bit   active = 0;
        int   n = 0;
        int   ack_cyc = -10;
        forever begin
            step();
            resp_ack = 1'b0;
            if (manual || !rst_n) begin
                active = 0;
                ack_cyc = -10;
                continue;
            end
            if (cyc == ack_cyc + 1) begin
                check("done_after_ack", done, 1);
                check("req_low_in_fin", mem_req, 0);
            end
            if (mem_req) begin
                if (!active) begin
                    if (bq.size() == 0) begin
                        check("unexpected_req", mem_req, 0);
                    end else begin
                        cur = bq.pop_front();
                        active = 1;
                        n = 0;
                        check("req_start_cycle", cyc, cur.icyc + 1);
                    end
                end
                if (active) begin
                    check("mem_we", mem_we, cur.we);
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_be", mem_be, cur.be);
                    check("mem_wdata", mem_wdata, cur.wdata);
                    if (n == cur.wt) begin
                        resp_ack = 1'b1;
                        mem_rdata = cur.rdata;
                        active = 0;
                        ack_cyc = cyc;
                    end else begin
                        n++;
                        mem_rdata = $urandom;
                    end
                end
            end else begin
                check("idle_we_be", {mem_we, mem_be}, 0);
                check("idle_addr", mem_addr, 0);
                check("idle_wdata", mem_wdata, 0);
                resp_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Completion monitor
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (rq.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    r = rq.pop_front();
                    completed++;
                    check("fault", fault, r.fault);
                    check("rdata", rdata, r.rdata);
                    check("ready_in_fin", ready, 1);
                    if (r.fault) check("fault_latency", cyc, r.icyc + 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, guard;
        #1;
        check_reset_values();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        issue(0, 3'b000, 32'h1003, 32'h0, 32'h80AA_BBCC, 0, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, c0);
        issue(0, 3'b101, 32'h2002, 32'h0, 32'h8001_1234, 0, 0, 4'b1100, 32'h0, 32'h0000_8001, c0);
        issue(1, 3'b001, 32'h12, 32'hDEAD_BEEF, 32'h0, 1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_8001, c0);
        issue(0, 3'b010, 32'h1001, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0000_8001, c0);
        issue(0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0000_8001, c0);

        issue(1, 3'b010, 32'h100, 32'h1234_5678, 32'h0, 3, 0, 4'b1111, 32'h1234_5678, 32'h0000_8001, c0);
        step();
        start = 1'b1; is_store = 1'b0; funct3 = 3'b000; addr = 32'h200;
        step();
        start = 1'b0;
        issue(0, 3'b100, 32'h5, 32'h0, 32'h0000_FF00, 0, 0, 4'b0010, 32'h0, 32'h0000_00FF, c1);
        check("fin_back_to_back_cycle", c1, c0 + 5);
        last_load = 32'h0000_00FF;

        issue(0, 3'b010, 32'h40, 32'h0, 32'h1, 40, 0, 4'b1111, 32'h0, 32'h0, c2);
        step();
        check("req_before_reset", mem_req, 1);
        manual = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        bq.delete();
        rq.delete();
        issued--;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        man_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_reset", done, 0);
            check("ready_after_reset", ready, 1);
            check("no_req_after_reset", mem_req, 0);
        end
        man_ack = 1'b0;
        manual = 1'b0;
        last_load = '0;
        step();

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) step();
            issue_rand();
        end

        guard = 0;
        while (rq.size() != 0 && guard < 300) begin
            step();
            guard++;
        end
        check("drain_pending", rq.size(), 0);
        check("completions", completed, issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
